// File: rtl/amp_audio_pkg.sv
// Shared constants and FSM encodings for the amp audio receive path.
package amp_audio_pkg;

  localparam int DW_DEF        = 16;
  localparam int SLOT_BITS_DEF = 32;
  localparam int FIFO_DEPTH    = 4;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } rx_state_t;

endpackage

// File: rtl/amp_sample_fifo.sv
// Show-ahead pair FIFO; a write into a full FIFO is accepted when a read happens in the same cycle.
module amp_sample_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_data,
  output logic         full,
  output logic         rd_vld,
  output logic [W-1:0] rd_data,
  input  logic         rd_rdy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop, push;

  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_vld  = (count != '0);
  assign rd_data = mem[rd_ptr];
  assign pop     = rd_vld && rd_rdy;
  assign push    = wr_vld && (!full || pop);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/amp_i2s_receiver.sv
// I2S slave receiver: oversampled deserialiser, lock tracking and pair hand-off.
// Define AMP_I2S_RX_FIFO_EN for a 4-entry pair FIFO instead of a single holding register.
module amp_i2s_receiver
  import amp_audio_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int SLOT_BITS   = SLOT_BITS_DEF,
  parameter int LOCK_FRAMES = 4,
  parameter int BCK_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          i2s_bck,
  input  logic          i2s_ws,
  input  logic          i2s_d0,
  output logic [DW-1:0] pcm_left,
  output logic [DW-1:0] pcm_right,
  output logic          pcm_valid,
  input  logic          pcm_ready,
  output logic          audio_locked,
  output logic          frame_err,
  output logic          overrun
);

  localparam int CW = $clog2(SLOT_BITS + 2) + 1;
  localparam int TW = $clog2(BCK_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_FRAMES + 1);

  logic bck_p0, bck_p1, bck_p2, ws_p0, ws_p1, d0_p0, d0_p1;
  logic bck_rise, boundary, timeout, slot_ok, slot_good;
  logic slot_err, left_load, pair_push, pop, buf_full;
  logic ws_prev;
  logic [CW-1:0] bit_cnt, cnt_inc;
  logic [TW-1:0] to_cnt;
  logic [LW-1:0] lock_cnt;
  logic [DW-1:0] sreg, word_next, left_word;
  rx_state_t     state, state_nxt;

  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
    return (v == LW'(LOCK_FRAMES)) ? v : v + 1'b1;
  endfunction

  // stage p0/p1: two-flop synchronisers; p2: bck edge-detect flop
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      {bck_p0, bck_p1, bck_p2} <= '0;
      {ws_p0, ws_p1, d0_p0, d0_p1} <= '0;
    end else begin
      bck_p0 <= i2s_bck;
      bck_p1 <= bck_p0;
      bck_p2 <= bck_p1;
      ws_p0  <= i2s_ws;
      ws_p1  <= ws_p0;
      d0_p0  <= i2s_d0;
      d0_p1  <= d0_p0;
    end
  end

  assign bck_rise  = bck_p1 & ~bck_p2;
  assign boundary  = bck_rise && (ws_p1 != ws_prev);
  assign timeout   = (to_cnt == TW'(BCK_TIMEOUT));
  assign cnt_inc   = (bit_cnt == '1) ? bit_cnt : bit_cnt + 1'b1;
  assign slot_ok   = (cnt_inc == CW'(SLOT_BITS));
  // Only the first DW bits of a slot form the word; later bits are counted but dropped.
  assign word_next = (bit_cnt < CW'(DW)) ? {sreg[DW-2:0], d0_p1} : sreg;
  assign slot_good = slot_ok && ((state == ST_LEFT && ws_p1) || (state == ST_RIGHT && !ws_p1));

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= ST_HUNT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = ST_HUNT;
    end else if (boundary) begin
      case (state)
        ST_HUNT:  if (!ws_p1) state_nxt = ST_LEFT;
        ST_LEFT,
        ST_RIGHT: begin
          if (slot_good) state_nxt = ws_p1 ? ST_RIGHT : ST_LEFT;
          else           state_nxt = ws_p1 ? ST_HUNT  : ST_LEFT;
        end
        default:  state_nxt = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    slot_err  = 1'b0;
    left_load = 1'b0;
    pair_push = 1'b0;
    if (!timeout && boundary && state != ST_HUNT) begin
      if (!slot_good)          slot_err  = 1'b1;
      else if (state == ST_LEFT) left_load = 1'b1;
      else                     pair_push = 1'b1;
    end
  end

  // stage p3: deserialiser, lock tracking and status pulses
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      ws_prev      <= 1'b0;
      bit_cnt      <= '0;
      sreg         <= '0;
      left_word    <= '0;
      to_cnt       <= '0;
      lock_cnt     <= '0;
      audio_locked <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_err    <= slot_err;
      overrun      <= pair_push && buf_full && !pop;
      audio_locked <= (lock_cnt == LW'(LOCK_FRAMES));
      to_cnt       <= bck_rise ? '0 : (timeout ? to_cnt : to_cnt + 1'b1);
      if (bck_rise) begin
        ws_prev <= ws_p1;
        if (boundary) begin
          bit_cnt <= '0;
          sreg    <= '0;
        end else begin
          bit_cnt <= cnt_inc;
          sreg    <= word_next;
        end
      end
      if (left_load) left_word <= word_next;
      if (timeout || slot_err) lock_cnt <= '0;
      else if (pair_push)      lock_cnt <= sat_inc(lock_cnt);
    end
  end

  assign pop = pcm_valid && pcm_ready;

`ifdef AMP_I2S_RX_FIFO_EN
  logic [2*DW-1:0] fifo_rd_data;

  amp_sample_fifo #(
    .W     (2*DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetb  (resetb),
    .wr_vld  (pair_push),
    .wr_data ({left_word, word_next}),
    .full    (buf_full),
    .rd_vld  (pcm_valid),
    .rd_data (fifo_rd_data),
    .rd_rdy  (pcm_ready)
  );

  assign {pcm_left, pcm_right} = fifo_rd_data;
`else
  assign buf_full = pcm_valid;

  // stage p4: single holding register; a pop frees it for a same-cycle push
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      pcm_valid <= 1'b0;
      pcm_left  <= '0;
      pcm_right <= '0;
    end else if (pair_push && (!pcm_valid || pcm_ready)) begin
      pcm_valid <= 1'b1;
      pcm_left  <= left_word;
      pcm_right <= word_next;
    end else if (pop) begin
      pcm_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_amp_i2s_receiver.sv
// Randomised bench for amp_i2s_receiver against a frame-level scoreboard and lock model.
module tb_amp_i2s_receiver;

  localparam int DW = 16;
  localparam int SB = 32;
  localparam int LOCK = 4;
`ifdef AMP_I2S_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0, resetb = 1'b0;
  logic i2s_bck = 1'b0, i2s_ws = 1'b0, i2s_d0 = 1'b0, pcm_ready = 1'b0;
  logic [DW-1:0] pcm_left, pcm_right;
  logic pcm_valid, audio_locked, frame_err, overrun;

  int errs = 0, checks = 0;
  int n_fe = 0, n_ovr = 0, n_xfer = 0;
  int good_run = 0, held = 0, exp_ovr = 0;
  bit stall = 1'b0;
  logic [2*DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  amp_i2s_receiver dut (
    .clk(clk), .resetb(resetb), .i2s_bck(i2s_bck), .i2s_ws(i2s_ws), .i2s_d0(i2s_d0),
    .pcm_left(pcm_left), .pcm_right(pcm_right), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
    .audio_locked(audio_locked), .frame_err(frame_err), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Output monitor: scoreboard on transfers, hold stability, pulse counting.
  logic fe_d = 1'b0, prev_hold = 1'b0;
  logic [2*DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (fe_d) chk("locked_after_ferr", audio_locked, 0);
    if (prev_hold && resetb) chk("hold_stable", {pcm_left, pcm_right}, prev_data);
    if (frame_err) n_fe++;
    if (overrun) n_ovr++;
    if (pcm_valid && pcm_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) chk("unexpected_pair", 0, 1);
      else chk("pair", {pcm_left, pcm_right}, exp_q.pop_front());
    end
    fe_d      = frame_err;
    prev_hold = pcm_valid && !pcm_ready;
    prev_data = {pcm_left, pcm_right};
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic ws, input logic d, input bit lat);
    i2s_bck = 1'b0;
    i2s_ws  = ws;
    i2s_d0  = d;
    repeat (4) tick();
    i2s_bck = 1'b1;
    if (lat) begin
      int k;
      k = 0;
      while (!pcm_valid && k < 8) begin
        @(negedge clk);
        k++;
      end
      chk("latency_le5", k <= 5, 1);
    end
    repeat (4) tick();
  endtask

  // ch = channel of the slot; the last bit already carries the other channel's ws.
  task automatic send_slot(input logic ch, input logic [31:0] data, input int nbits, input bit lat);
    for (int i = 0; i < nbits; i++)
      send_bit((i == nbits - 1) ? ~ch : ch, data[31-i], lat && (i == nbits - 1));
  endtask

  task automatic settle_lock();
    repeat (4) @(negedge clk);
    chk("locked", audio_locked, good_run >= LOCK);
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input int lbits, input bit expect_pair, input bit lat);
    logic [31:0] ls, rs;
    ls = {l, 16'($urandom)};
    rs = {r, 16'($urandom)};
    if (lbits != SB) good_run = 0;
    send_slot(1'b0, ls, lbits, 1'b0);
    if (expect_pair) begin
      good_run++;
      if (stall && held >= CAP) exp_ovr++;
      else begin
        exp_q.push_back({l, r});
        if (stall) held++;
      end
    end
    send_slot(1'b1, rs, SB, lat);
    settle_lock();
  endtask

  task automatic rand_frames(input int n, input bit first_expected);
    for (int i = 0; i < n; i++)
      send_frame(16'($urandom), 16'($urandom), SB, first_expected || i > 0, 1'b0);
  endtask

  int fe0, ovr0, x0;
  bit tog_stop;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {pcm_left, pcm_right, pcm_valid, audio_locked, frame_err, overrun}, 0);
    resetb = 1'b1;
    pcm_ready = 1'b1;
    repeat (3) tick();

    // 1: fixed pattern, first frame used for alignment, then lock after 4 pairs
    send_frame(16'h1234, 16'hABCD, SB, 1'b0, 1'b0);
    send_frame(16'h1234, 16'hABCD, SB, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_frame(16'h1234, 16'hABCD, SB, 1'b1, 1'b0);
    rand_frames(3, 1'b1);

    // 2: short left slot
    fe0 = n_fe;
    send_frame(16'($urandom), 16'($urandom), SB - 1, 1'b0, 1'b0);
    chk("ferr_count_short", n_fe - fe0, 1);
    rand_frames(4, 1'b1);

    // 3: bck stall -> lock lost without frame_err
    fe0 = n_fe;
    repeat (100) @(negedge clk);
    good_run = 0;
    chk("locked_timeout", audio_locked, 0);
    chk("ferr_count_timeout", n_fe - fe0, 0);
    rand_frames(5, 1'b0);

    // 4: consumer stalled for 5 pairs
    pcm_ready = 1'b0;
    stall = 1'b1;
    held = 0;
    exp_ovr = 0;
    ovr0 = n_ovr;
    x0 = n_xfer;
    rand_frames(5, 1'b1);
    chk("overrun_count", n_ovr - ovr0, exp_ovr);
    chk("held_first", {pcm_valid, pcm_left, pcm_right}, {1'b1, exp_q[0]});
    pcm_ready = 1'b1;
    stall = 1'b0;
    held = 0;
    repeat (10) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_xfers", n_xfer - x0, CAP);

    // 5: reset in the middle of a right slot
    pcm_ready = 1'b0;
    stall = 1'b1;
    send_frame(16'($urandom), 16'($urandom), SB, 1'b1, 1'b0);
    send_slot(1'b0, 32'($urandom), SB, 1'b0);
    for (int i = 0; i < 16; i++) send_bit(1'b1, 1'($urandom), 1'b0);
    resetb = 1'b0;
    @(negedge clk);
    chk("reset_mid_outputs", {pcm_left, pcm_right, pcm_valid, audio_locked, frame_err, overrun}, 0);
    exp_q.delete();
    held = 0;
    stall = 1'b0;
    good_run = 0;
    repeat (2) tick();
    resetb = 1'b1;
    pcm_ready = 1'b1;
    x0 = n_xfer;
    for (int i = 0; i < 15; i++) send_bit(1'b1, 1'($urandom), 1'b0);
    send_bit(1'b0, 1'($urandom), 1'b0);
    repeat (6) @(negedge clk);
    chk("no_pair_after_reset", {pcm_valid, 32'(n_xfer - x0)}, 0);
    rand_frames(4, 1'b1);

    // 6: extreme values with ready toggling every cycle
    x0 = n_xfer;
    tog_stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) send_frame(16'h8000, 16'h7FFF, SB, 1'b1, 1'b0);
        rand_frames(2, 1'b1);
        tog_stop = 1'b1;
      end
      begin
        while (!tog_stop) begin
          tick();
          pcm_ready = ~pcm_ready;
        end
      end
    join
    pcm_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("toggle_empty", exp_q.size(), 0);
    chk("toggle_xfers", n_xfer - x0, 5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
